// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit producing HI/LO for mfhi/mflo.
// Booth radix-2 multiply and restoring divide, 32 iterations each, start/busy/done handshake.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  // acc is one bit wider than the operands so Booth never overflows on -(-2^31).
  logic [32:0] acc;
  logic [32:0] m;
  logic [31:0] q;
  logic        q_1;
  logic        is_div, neg_q, neg_r;

  logic        busy_nx, done_nx, dz_nx;
  logic        div_accept;
  logic [32:0] booth_sum, div_shift, div_diff;
  logic        div_ge;
  logic [31:0] abs_a, abs_b, hi_fin, lo_fin;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign div_accept = !mult_start && div_start && (b != 32'd0);

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no latches are inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mult_start)      state_nx = MULT;
        else if (div_accept) state_nx = DIV;
      end
      MULT:    if (cnt == 5'd31) state_nx = FINISH;
      DIV:     if (cnt == 5'd31) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake outputs.
  always_comb begin
    busy_nx = (state_nx != IDLE);
    done_nx = (state == FINISH);
    dz_nx   = (state == IDLE) && !mult_start && div_start && (b == 32'd0);
  end

  // One Booth step and one restoring-divide step, plus the final sign fix-up.
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    div_shift = {acc[31:0], q[31]};
    div_ge    = (div_shift >= m);
    div_diff  = div_shift - m;
    abs_a     = a[31] ? 32'd0 - a : a;
    abs_b     = b[31] ? 32'd0 - b : b;
    lo_fin    = (is_div && neg_q) ? 32'd0 - q : q;
    hi_fin    = (is_div && neg_r) ? 32'd0 - acc[31:0] : acc[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      busy     <= busy_nx;
      done     <= done_nx;
      div_zero <= dz_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mult_start) begin
            acc    <= '0;
            m      <= {a[31], a};
            q      <= b;
            q_1    <= 1'b0;
            is_div <= 1'b0;
          end else if (div_accept) begin
            // Divide magnitudes; signs are restored in FINISH.
            acc    <= '0;
            m      <= {1'b0, abs_b};
            q      <= abs_a;
            q_1    <= 1'b0;
            is_div <= 1'b1;
            neg_q  <= a[31] ^ b[31];
            neg_r  <= a[31];
          end
        end
        MULT: begin
          acc <= {booth_sum[32], booth_sum[32:1]};
          q   <= {booth_sum[0], q[31:1]};
          q_1 <= q[0];
          cnt <= cnt + 5'd1;
        end
        DIV: begin
          acc <= div_ge ? div_diff : div_shift;
          q   <= {q[30:0], div_ge};
          cnt <= cnt + 5'd1;
        end
        FINISH: begin
          hi_out <= hi_fin;
          lo_out <= lo_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random ops against an arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, mult_start, div_start;
  logic [31:0] a, b, hi_out, lo_out;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic (/ truncates toward zero, % follows dividend).
  function automatic void model(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sx, sy, r, rq, rr;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (!is_div) begin
      r = sx * sy;
      h = r[63:32];
      l = r[31:0];
    end else begin
      rq = sx / sy;
      rr = sx % sy;
      h = rr[31:0];
      l = rq[31:0];
    end
  endfunction

  // Issue one op, watch 40 cycles, then check result, busy length and done timing.
  task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                        input logic [31:0] x, input logic [31:0] y, input int inject);
    int busy_cnt, done_cnt, done_at;
    @(negedge clk);
    a = x; b = y; mult_start = do_mult; div_start = do_div;
    @(posedge clk);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (j == 0) begin mult_start = 0; div_start = 0; end
      if (j == inject) begin mult_start = 1; a = ~x; b = y + 32'd3; end
      if (j == inject + 1) mult_start = 0;
    end
    model(!do_mult, x, y, exp_hi, exp_lo);
    check({tag, " hi"}, hi_out, exp_hi);
    check({tag, " lo"}, lo_out, exp_lo);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_at"}, 32'(done_at), 32'd33);
  endtask

  initial begin
    int bad;
    logic [31:0] rx, ry;
    bit rm;
    reset = 1; mult_start = 1; div_start = 0; a = 32'd3; b = 32'd4;
    repeat (2) @(negedge clk);
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    reset = 0; mult_start = 0;
    @(negedge clk);

    run_op("mul 7*-3", 1, 0, 32'd7, 32'hFFFFFFFD, -5);
    check("mul 7*-3 hi const", hi_out, 32'hFFFFFFFF);
    check("mul 7*-3 lo const", lo_out, 32'hFFFFFFEB);
    run_op("mul min*min", 1, 0, 32'h80000000, 32'h80000000, -5);
    check("mul min*min hi const", hi_out, 32'h40000000);
    run_op("div -7/2", 0, 1, 32'hFFFFFFF9, 32'd2, -5);
    check("div -7/2 lo const", lo_out, 32'hFFFFFFFD);
    run_op("div min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, -5);
    check("div min/-1 lo const", lo_out, 32'h80000000);
    run_op("div 5/2", 0, 1, 32'd5, 32'd2, -5);

    // Divide by zero: pulse only, HI/LO untouched.
    @(negedge clk);
    a = 32'd9; b = 32'd0; div_start = 1;
    @(posedge clk);
    @(negedge clk);
    div_start = 0;
    check("dz pulse", {31'd0, div_zero}, 32'd1);
    check("dz busy", {31'd0, busy}, 32'd0);
    check("dz done", {31'd0, done}, 32'd0);
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (div_zero || busy || done) bad++;
    end
    check("dz after", 32'(bad), 32'd0);
    check("dz hi kept", hi_out, 32'h1);
    check("dz lo kept", lo_out, 32'h2);

    run_op("mul ignore restart", 1, 0, 32'd12345, 32'hFFFF0001, 10);
    run_op("both starts", 1, 1, 32'd100, 32'd7, -5);

    // Reset in the middle of a divide.
    @(negedge clk);
    a = 32'd1000; b = 32'd7; div_start = 1;
    @(posedge clk);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      div_start = 0;
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst mid hi", hi_out, 32'd0);
    check("rst mid lo", lo_out, 32'd0);
    check("rst mid busy", {31'd0, busy}, 32'd0);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("rst mid quiet", 32'(bad), 32'd0);
    run_op("mul after reset", 1, 0, 32'hFFFFFF00, 32'd3, -5);

    for (int i = 0; i < 10; i++) begin
      rm = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      if (i < 3) ry = ry >> 20;
      if (!rm && ry == 32'd0) ry = 32'd1;
      run_op(rm ? "rand mul" : "rand div", rm, !rm, rx, ry, -5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
